// File: rtl/an_tx_cfg_ctrl.sv
// AN_TX gain/balance sequencer: debounced preset stepping, JTAG target loads,
// and a one-LSB-per-tick ramp of both outputs toward the current target.
module an_tx_cfg_ctrl #(
   parameter int unsigned C_DEB_CKN  = 1_350_000,
   parameter int unsigned C_RAMP_CKN = 135_000
) (
   input  logic       CK_i,
   input  logic       ARST_i,
   input  logic       XPSW_i,
   input  logic       JTAG_REQ_i,
   input  logic [5:0] JTAG_GAINs_i,
   input  logic [5:0] JTAG_BALANCEs_i,
   output logic [5:0] BUS_GAINs_o,
   output logic [5:0] BUS_BALANCEs_o,
   output logic [1:0] PRESETs_o,
   output logic       BUSY_o,
   output logic       PSW_PULSE_o
);
   localparam int unsigned W_DEB  = $clog2(C_DEB_CKN + 1);
   localparam int unsigned W_RAMP = $clog2(C_RAMP_CKN + 1);
   localparam logic [W_DEB-1:0]  C_DEB_LAST  = W_DEB'(C_DEB_CKN - 1);
   localparam logic [W_RAMP-1:0] C_RAMP_LAST = W_RAMP'(C_RAMP_CKN - 1);
   localparam logic [5:0]        C_BAL_PRESET = 6'h3F;

   typedef enum logic {StIdle, StRamp} state_t;

   function automatic logic [5:0] f_preset_gain(input logic [1:0] idx);
      logic [5:0] g;
      unique case (idx)
         2'd0:    g = 6'h01;
         2'd1:    g = 6'h04;
         2'd2:    g = 6'h10;
         default: g = 6'h3F;
      endcase
      return g;
   endfunction

   function automatic logic [5:0] f_step(input logic [5:0] cur, input logic [5:0] tgt);
      if (cur < tgt)      return cur + 6'd1;
      else if (cur > tgt) return cur - 6'd1;
      else                return cur;
   endfunction

   logic [1:0]        r_psw_sync;
   logic [1:0]        r_jtag_sync;
   logic              r_jtag_dly;
   logic              r_psw_deb;
   logic [W_DEB-1:0]  r_deb_cnt;
   logic              r_psw_pulse;
   logic              r_pend;
   logic [1:0]        r_preset;
   logic [5:0]        r_tgt_gain;
   logic [5:0]        r_tgt_bal;
   logic [W_RAMP-1:0] r_presc;
   logic [5:0]        r_gain;
   logic [5:0]        r_bal;
   logic              r_busy;
   state_t            r_state;

   logic              w_psw_lvl;
   logic              w_jtag_evt;
   logic              w_load;
   logic              w_tick;
   logic              w_neq;
   logic              w_deb_nxt;
   logic [W_DEB-1:0]  w_deb_cnt_nxt;
   logic              w_pulse_nxt;
   logic              w_pend_nxt;
   logic [1:0]        w_preset_nxt;
   logic [5:0]        w_tgt_gain_nxt;
   logic [5:0]        w_tgt_bal_nxt;
   logic [W_RAMP-1:0] w_presc_nxt;
   logic [5:0]        w_gain_nxt;
   logic [5:0]        w_bal_nxt;
   state_t            w_state_nxt;

   // The switch is kept in "pressed" sense so a cleared synchroniser reads as released.
   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         r_psw_sync  <= '0;
         r_jtag_sync <= '0;
         r_jtag_dly  <= 1'b0;
      end else begin
         r_psw_sync  <= {r_psw_sync[0], ~XPSW_i};
         r_jtag_sync <= {r_jtag_sync[0], JTAG_REQ_i};
         r_jtag_dly  <= r_jtag_sync[1];
      end
   end

   assign w_psw_lvl  = r_psw_sync[1];
   assign w_jtag_evt = r_jtag_sync[1] & ~r_jtag_dly;

   always_comb begin
      w_deb_nxt      = r_psw_deb;
      w_deb_cnt_nxt  = '0;
      w_pulse_nxt    = 1'b0;
      w_pend_nxt     = r_pend;
      w_preset_nxt   = r_preset;
      w_tgt_gain_nxt = r_tgt_gain;
      w_tgt_bal_nxt  = r_tgt_bal;
      w_load         = 1'b0;
      w_tick         = 1'b0;
      w_presc_nxt    = r_presc + 1'b1;
      w_gain_nxt     = r_gain;
      w_bal_nxt      = r_bal;
      w_neq          = 1'b0;
      w_state_nxt    = r_state;

      if (w_psw_lvl != r_psw_deb) begin
         if (r_deb_cnt == C_DEB_LAST) begin
            w_deb_nxt   = w_psw_lvl;
            w_pulse_nxt = w_psw_lvl;
         end else begin
            w_deb_cnt_nxt = r_deb_cnt + 1'b1;
         end
      end

      // JTAG wins a collision; the press is parked and overrides it one cycle later.
      if (w_jtag_evt) begin
         w_load         = 1'b1;
         w_tgt_gain_nxt = JTAG_GAINs_i;
         w_tgt_bal_nxt  = JTAG_BALANCEs_i;
         if (r_psw_pulse) w_pend_nxt = 1'b1;
      end else if (r_psw_pulse || r_pend) begin
         w_load         = 1'b1;
         w_preset_nxt   = r_preset + 2'd1;
         w_tgt_gain_nxt = f_preset_gain(w_preset_nxt);
         w_tgt_bal_nxt  = C_BAL_PRESET;
         w_pend_nxt     = 1'b0;
      end

      w_tick = (r_presc == C_RAMP_LAST) && !w_load;
      if (w_load || w_tick) w_presc_nxt = '0;

      unique case (r_state)
         StRamp: begin
            if (w_tick) begin
               w_gain_nxt = f_step(r_gain, w_tgt_gain_nxt);
               w_bal_nxt  = f_step(r_bal, w_tgt_bal_nxt);
            end
         end
         default: ;
      endcase

      w_neq = (w_gain_nxt != w_tgt_gain_nxt) || (w_bal_nxt != w_tgt_bal_nxt);
      unique case (r_state)
         StIdle:  if (w_load && w_neq) w_state_nxt = StRamp;
         default: if (!w_neq) w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         r_psw_deb   <= 1'b0;
         r_deb_cnt   <= '0;
         r_psw_pulse <= 1'b0;
         r_pend      <= 1'b0;
         r_preset    <= 2'd0;
         r_tgt_gain  <= 6'h01;
         r_tgt_bal   <= C_BAL_PRESET;
         r_presc     <= '0;
         r_gain      <= 6'h00;
         r_bal       <= 6'h3F;
         r_busy      <= 1'b1;
         r_state     <= StRamp;
      end else begin
         r_psw_deb   <= w_deb_nxt;
         r_deb_cnt   <= w_deb_cnt_nxt;
         r_psw_pulse <= w_pulse_nxt;
         r_pend      <= w_pend_nxt;
         r_preset    <= w_preset_nxt;
         r_tgt_gain  <= w_tgt_gain_nxt;
         r_tgt_bal   <= w_tgt_bal_nxt;
         r_presc     <= w_presc_nxt;
         r_gain      <= w_gain_nxt;
         r_bal       <= w_bal_nxt;
         r_busy      <= w_neq;
         r_state     <= w_state_nxt;
      end
   end

   assign BUS_GAINs_o    = r_gain;
   assign BUS_BALANCEs_o = r_bal;
   assign PRESETs_o      = r_preset;
   assign BUSY_o         = r_busy;
   assign PSW_PULSE_o    = r_psw_pulse;

endmodule

// File: tb/tb_an_tx_cfg_ctrl.sv
// Bench for an_tx_cfg_ctrl: per-cycle comparison against an edge-history reference
// model, a table of preset/JTAG operations, and hand-written collision/reset sequences.
module tb_an_tx_cfg_ctrl;
   localparam int unsigned C_DEB  = 4;
   localparam int unsigned C_RAMP = 8;
   localparam int          MAXN   = 16384;
   localparam int          BOUND  = 2000;

   logic       ck   = 1'b0;
   logic       arst = 1'b1;
   logic       xpsw = 1'b1;
   logic       jreq = 1'b0;
   logic [5:0] jg   = 6'h00;
   logic [5:0] jb   = 6'h00;
   logic [5:0] gain;
   logic [5:0] bal;
   logic [1:0] preset;
   logic       busy;
   logic       pulse;

   an_tx_cfg_ctrl #(
      .C_DEB_CKN (C_DEB),
      .C_RAMP_CKN(C_RAMP)
   ) dut (
      .CK_i           (ck),
      .ARST_i         (arst),
      .XPSW_i         (xpsw),
      .JTAG_REQ_i     (jreq),
      .JTAG_GAINs_i   (jg),
      .JTAG_BALANCEs_i(jb),
      .BUS_GAINs_o    (gain),
      .BUS_BALANCEs_o (bal),
      .PRESETs_o      (preset),
      .BUSY_o         (busy),
      .PSW_PULSE_o    (pulse)
   );

   always #5 ck = ~ck;

   int checks   = 0;
   int failures = 0;
   int pcnt     = 0;

   logic [5:0] PGAIN [4];

   // Reference model: histories indexed by clock edge since reset release.
   bit         press_h [MAXN];
   bit         req_h   [MAXN];
   int         m_n, m_load_n, m_last_acc, m_preset;
   bit         m_deb, m_pend, m_rose_prev;
   logic [5:0] m_bg, m_bb, m_tg, m_tb;
   logic [5:0] e_g, e_b;
   bit         e_busy, e_pulse;

   function automatic bit ph(input int i);
      return (i >= 1) ? press_h[i] : 1'b0;
   endfunction

   function automatic bit rq(input int i);
      return (i >= 1) ? req_h[i] : 1'b0;
   endfunction

   // Value reached from a after k single-LSB steps toward t.
   function automatic logic [5:0] mv(input logic [5:0] a, input logic [5:0] t, input int k);
      int ai, ti;
      ai = int'(a);
      ti = int'(t);
      if (ai < ti) return 6'((ai + k > ti) ? ti : ai + k);
      return 6'((ai - k < ti) ? ti : ai - k);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_load_n = 0; m_last_acc = 0; m_preset = 0;
      m_deb = 0; m_pend = 0; m_rose_prev = 0;
      m_bg = 6'h00; m_bb = 6'h3F; m_tg = 6'h01; m_tb = 6'h3F;
      e_g = 6'h00; e_b = 6'h3F; e_busy = 1; e_pulse = 0;
   endtask

   task automatic model_edge();
      bit         acc, rose, press, jt, load;
      logic [5:0] pg, pb, ng, nb;
      m_n++;
      if (m_n >= MAXN) begin
         $display("FAIL model_history: edge count %0d exceeds %0d", m_n, MAXN);
         $fatal(1);
      end
      press_h[m_n] = ~xpsw;
      req_h[m_n]   = jreq;
      // Accept a level once it has differed from the debounced state for C_DEB edges.
      acc = (m_n - int'(C_DEB) + 1 > m_last_acc);
      for (int j = 0; j < int'(C_DEB); j++)
         if (ph(m_n - j - 2) == m_deb) acc = 0;
      rose = 0;
      if (acc) begin
         m_deb = ~m_deb;
         m_last_acc = m_n;
         rose = m_deb;
      end
      press = m_rose_prev;
      m_rose_prev = rose;
      e_pulse = rose;
      jt = rq(m_n - 2) & ~rq(m_n - 3);
      pg = mv(m_bg, m_tg, (m_n - 1 - m_load_n) / int'(C_RAMP));
      pb = mv(m_bb, m_tb, (m_n - 1 - m_load_n) / int'(C_RAMP));
      load = 0; ng = m_tg; nb = m_tb;
      if (jt) begin
         load = 1; ng = jg; nb = jb;
         if (press) m_pend = 1;
      end else if (press || m_pend) begin
         m_preset = (m_preset + 1) % 4;
         load = 1; ng = PGAIN[m_preset]; nb = 6'h3F;
         m_pend = 0;
      end
      if (load) begin
         m_bg = pg; m_bb = pb; m_tg = ng; m_tb = nb; m_load_n = m_n;
      end
      e_g = mv(m_bg, m_tg, (m_n - m_load_n) / int'(C_RAMP));
      e_b = mv(m_bb, m_tb, (m_n - m_load_n) / int'(C_RAMP));
      e_busy = (e_g != m_tg) || (e_b != m_tb);
   endtask

   task automatic check_all();
      chk("gain", int'(gain), int'(e_g));
      chk("balance", int'(bal), int'(e_b));
      chk("preset", int'(preset), m_preset);
      chk("busy", int'(busy), int'(e_busy));
      chk("psw_pulse", int'(pulse), int'(e_pulse));
   endtask

   task automatic cyc();
      @(posedge ck);
      model_edge();
      @(negedge ck);
      check_all();
      if (pulse === 1'b1) pcnt++;
   endtask

   // Called from a falling edge; asserts reset between clock edges.
   task automatic apply_reset();
      #2 arst = 1'b1;
      #1;
      chk("arst_gain", int'(gain), 'h00);
      chk("arst_balance", int'(bal), 'h3F);
      chk("arst_preset", int'(preset), 0);
      chk("arst_pulse", int'(pulse), 0);
      xpsw = 1'b1;
      jreq = 1'b0;
      @(negedge ck);
      @(negedge ck);
      arst = 1'b0;
      model_reset();
      check_all();
   endtask

   task automatic press(input int low_cycles);
      xpsw = 1'b0;
      repeat (low_cycles) cyc();
      xpsw = 1'b1;
      repeat (8) cyc();
   endtask

   task automatic jtag_load(input logic [5:0] g, input logic [5:0] b);
      jg = g;
      jb = b;
      repeat (2) cyc();
      jreq = 1'b1;
      repeat (4) cyc();
      jreq = 1'b0;
      repeat (2) cyc();
   endtask

   task automatic settle();
      int k;
      k = 0;
      while (busy && k < BOUND) begin
         cyc();
         k++;
      end
      chk("settle_within_bound", (k < BOUND) ? 1 : 0, 1);
   endtask

   typedef struct {
      int         op;       // 0 = switch press, 1 = JTAG load
      logic [5:0] jg;
      logic [5:0] jb;
      int         exp_preset;
      logic [5:0] exp_g;
      logic [5:0] exp_b;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [5:0] g0;
      int         r;
      PGAIN[0] = 6'h01; PGAIN[1] = 6'h04; PGAIN[2] = 6'h10; PGAIN[3] = 6'h3F;
      vecs[0] = '{0, 6'h00, 6'h00, 1, 6'h04, 6'h3F};
      vecs[1] = '{0, 6'h00, 6'h00, 2, 6'h10, 6'h3F};
      vecs[2] = '{0, 6'h00, 6'h00, 3, 6'h3F, 6'h3F};
      vecs[3] = '{0, 6'h00, 6'h00, 0, 6'h01, 6'h3F};
      vecs[4] = '{1, 6'h05, 6'h20, 0, 6'h05, 6'h20};
      vecs[5] = '{1, 6'h3F, 6'h00, 0, 6'h3F, 6'h00};
      vecs[6] = '{0, 6'h00, 6'h00, 1, 6'h04, 6'h3F};

      @(negedge ck);
      apply_reset();
      chk("release_busy", int'(busy), 1);
      repeat (7) cyc();
      chk("first_step_not_early", int'(gain), 'h00);
      cyc();
      chk("first_step_gain", int'(gain), 'h01);
      chk("first_step_busy", int'(busy), 0);

      // Three-cycle glitch must be rejected.
      pcnt = 0;
      xpsw = 1'b0;
      repeat (3) cyc();
      xpsw = 1'b1;
      repeat (12) cyc();
      chk("glitch_no_pulse", pcnt, 0);
      chk("glitch_preset", int'(preset), 0);

      for (int i = 0; i < 7; i++) begin
         pcnt = 0;
         if (vecs[i].op == 0) press(20);
         else jtag_load(vecs[i].jg, vecs[i].jb);
         settle();
         chk($sformatf("vec%0d_preset", i), int'(preset), vecs[i].exp_preset);
         chk($sformatf("vec%0d_gain", i), int'(gain), int'(vecs[i].exp_g));
         chk($sformatf("vec%0d_balance", i), int'(bal), int'(vecs[i].exp_b));
         chk($sformatf("vec%0d_pulses", i), pcnt, (vecs[i].op == 0) ? 1 : 0);
      end

      // Collision: press event and JTAG edge land on the same cycle; preset 1 -> 2.
      jg = 6'h2A;
      jb = 6'h15;
      repeat (3) cyc();
      pcnt = 0;
      xpsw = 1'b0;
      repeat (4) cyc();
      jreq = 1'b1;
      repeat (20) cyc();
      xpsw = 1'b1;
      jreq = 1'b0;
      repeat (4) cyc();
      settle();
      chk("collide_preset", int'(preset), 2);
      chk("collide_gain", int'(gain), 'h10);
      chk("collide_balance", int'(bal), 'h3F);
      chk("collide_pulses", pcnt, 1);

      // Retarget an upward ramp downward, then reset in the middle of that ramp.
      jtag_load(6'h01, 6'h3F);
      settle();
      jtag_load(6'h30, 6'h3F);
      repeat (60) cyc();
      jtag_load(6'h05, 6'h3F);
      g0 = e_g;
      repeat (C_RAMP) cyc();
      chk("retarget_down", int'(gain), int'(g0) - 1);
      repeat (3) cyc();
      apply_reset();
      repeat (C_RAMP) cyc();
      chk("post_reset_gain", int'(gain), 'h01);
      chk("post_reset_busy", int'(busy), 0);

      // Randomised traffic checked cycle by cycle against the model.
      for (int i = 0; i < 250; i++) begin
         r = int'($urandom_range(0, 3));
         if (r == 0) begin
            xpsw = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) cyc();
         end else if (r == 1) begin
            jtag_load(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
         end else begin
            repeat ($urandom_range(1, 30)) cyc();
         end
      end
      xpsw = 1'b1;
      repeat (10) cyc();
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/an_tx_cfg_ctrl.md
Name: an_tx_cfg_ctrl

Overview:
Configuration sequencer for the AN_TX tone/delta-sigma datapath. It generates the BUS_GAINs and BUS_BALANCEs settings that AN_TX consumes. Two requesters can change the target: the board push switch, which steps through a fixed preset table, and the JTAG debugger source, which loads arbitrary values. Outputs ramp one LSB per tick toward the target, so gain and balance changes produce no audible clicks. The block sits between the board I/O / JTAG_DBGER and AN_TX in the top level.

Parameters:
C_DEB_CKN, 1_350_000, consecutive stable cycles required to accept a switch level change (10 ms at 135 MHz)
C_RAMP_CKN, 135_000, cycles per ramp step (1 ms at 135 MHz)

Ports:
CK_i  input  1  system clock, 135 MHz
ARST_i  input  1  asynchronous reset, active-high
XPSW_i  input  1  raw push switch, active-low, asynchronous
JTAG_REQ_i  input  1  JTAG load request level, asynchronous; a rising edge requests a load
JTAG_GAINs_i  input  6  JTAG target gain; must be held stable for 4 cycles around the JTAG_REQ_i edge
JTAG_BALANCEs_i  input  6  JTAG target balance; same stability rule
BUS_GAINs_o  output  6  current gain to AN_TX
BUS_BALANCEs_o  output  6  current balance to AN_TX
PRESETs_o  output  2  current preset index
BUSY_o  output  1  high while either output differs from its target
PSW_PULSE_o  output  1  one-cycle debounced press strobe, for the LED/debug probe

Behaviour:
- Reset (async, ARST_i=1):
  - BUS_GAINs_o=6'h00, BUS_BALANCEs_o=6'h3F, PRESETs_o=0, PSW_PULSE_o=0.
  - Targets load preset 0. Debounce counter, prescaler, synchronisers and pending flag clear. The debounced switch state is "released".
- Reset release mid-ramp: the ramp restarts from the reset values. No other recovery is needed.
- Preset table (gain/balance):
  - 0: 01/3F
  - 1: 04/3F
  - 2: 10/3F
  - 3: 3F/3F
- Switch path:
  - 2-FF synchroniser, then inversion to "pressed".
  - Counter increments each cycle the synced level differs from the debounced state. The counter clears on any cycle where they match.
  - On reaching C_DEB_CKN, the debounced state takes the synced level and the counter clears.
  - A released->pressed transition asserts PSW_PULSE_o for exactly 1 cycle, the cycle after the state update.
  - Releases produce no event.
- JTAG path: 2-FF synchroniser plus rising-edge detect. JTAG_GAINs_i/JTAG_BALANCEs_i are sampled in the edge-detect cycle.
- Arbitration (per cycle):
  - JTAG event only: targets = JTAG values; PRESETs_o unchanged.
  - Press event only: PRESETs_o = PRESETs_o+1 mod 4 (3 wraps to 0); targets = new preset entry.
  - Both in the same cycle: JTAG wins. The press sets a pending flag and is applied the next cycle, so it overrides the JTAG target.
  - Only one pending press is held. A further press while one is pending is dropped.
- Target load: any load clears the ramp prescaler to 0.
- Ramp:
  - The prescaler counts 0..C_RAMP_CKN-1 and issues a tick at terminal count.
  - The first step occurs exactly C_RAMP_CKN cycles after the load cycle.
  - On each tick, gain and balance each move independently by ±1 toward their target, or hold if equal.
  - Unsigned 6-bit values only; no overshoot or wrap is possible.
- Retarget mid-ramp: the ramp continues from the current value toward the new target.
- Outputs: all outputs are registered. BUSY_o = (gain≠target_gain)|(bal≠target_bal), registered, updated in the same cycle as the outputs/targets.
- State machine:
  - IDLE: outputs equal targets, BUSY_o=0, prescaler free-runs.
  - IDLE→RAMP on a target load that differs from the current outputs. A load equal to the current outputs stays in IDLE.
  - RAMP→IDLE on the tick that makes both outputs equal their targets.

Test Plan:
- Bench parameters: C_DEB_CKN=4, C_RAMP_CKN=8.
- Reset → BUS_GAINs_o=00, BUS_BALANCEs_o=3F, BUSY_o=1 immediately after release. Exactly 8 cycles after release, gain=01, BUSY_o=0, PRESETs_o=0.
- Debounce:
  - XPSW_i low for 3 cycles, then high → no PSW_PULSE_o.
  - XPSW_i low for 20 cycles → exactly one PSW_PULSE_o, PRESETs_o=1. Gain ramps 01→04 in steps at +8, +16 and +24 cycles after the load, then BUSY_o=0.
- Wrap: four clean presses from preset 0 → PRESETs_o sequence 1,2,3,0. After settling at preset 3, gain=3F; back at preset 0 it ramps down 3F→01 over 62 ticks (496 cycles).
- JTAG load: JTAG_GAINs_i=05, JTAG_BALANCEs_i=20, JTAG_REQ_i rising → PRESETs_o unchanged. Balance decrements 3F→20 (31 ticks) while gain moves to 05 in parallel. BUSY_o falls on tick 31.
- Collision: press event and JTAG edge in the same cycle → JTAG target loads first, the preset target overrides next cycle. Final outputs equal the next preset entry, PRESETs_o advances by 1.
- Retarget mid-ramp plus ARST_i mid-ramp:
  - A JTAG load issued during an upward gain ramp reverses direction on the next tick.
  - ARST_i asserted mid-ramp forces 00/3F/preset 0 asynchronously, without waiting for CK_i.
